dp_seq_engine: RTL and testbench
================================

# dp_seq_engine

Parametrised register-file datapath with an internal sequencer that runs one ALU instruction per start request through FETCH, EXEC and WRITEBACK states. It generalises the team's fixed 8-bit, four-register datapath to WIDTH bits and NREG registers. It adds a wider ALU, status flags and a start/busy/done handshake, so the surrounding control FSM issues whole instructions instead of per-cycle selects. R0 drives `out` directly.

## Interface
- WIDTH, 8, datapath and register width in bits (≥2)
- NREG, 4, number of general registers; power of two, ≥2; RW = $clog2(NREG)

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in  in  WIDTH  external load data
- ld  in  1  load `in` into R[rd] (honoured only in IDLE)
- start  in  1  begin instruction (honoured only in IDLE)
- op  in  3  ALU operation, sampled with start
- rd, ra, rb  in  RW each  destination, A-source and B-source register indices, sampled with start or ld
- busy  out  1  high in FETCH, EXEC and WB
- done  out  1  one-cycle pulse after writeback
- out  out  WIDTH  current R0
- z, n, c  out  1 each  zero, negative (MSB) and carry/borrow flags

## Operation
- State: R[0..NREG-1], tmp, res (WIDTH each), latched op/rd/rb, flags, and a 2-bit FSM (IDLE, FETCH, EXEC, WB).
- IDLE:
  - start=1: latch op, rd, ra, rb; go to FETCH.
  - start=0 and ld=1: R[rd] <= in; stay in IDLE. No flag change and no done pulse.
  - start=1 and ld=1 together: start wins; ld is dropped.
- FETCH: tmp <= R[ra]; go to EXEC.
- EXEC: res <= alu(tmp, R[rb]); the carry candidate is latched as well; go to WB.
- WB: R[rd] <= res; update z, n, c; go to IDLE.
- ALU results are modulo 2^WIDTH:
  - 000 ADD: tmp+B; c = carry out
  - 001 SUB: tmp-B; c = borrow (tmp<B unsigned)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL: tmp<<1; c = tmp[MSB]
  - 110 SHR: logical tmp>>1; c = tmp[0]
  - 111 MOVB: result is B
- Flags:
  - c is cleared for AND, OR, XOR and MOVB.
  - z = (res==0); n = res[WIDTH-1].
  - Flags hold their value between instructions.
- Register aliasing (rd==ra==rb) is legal. Operands are read in FETCH/EXEC, before the WB write.
- start, ld and their operands are ignored while busy=1. No queuing.

## Timing
- Reset values: all R, tmp, res = 0; z=n=c=0; busy=0; done=0; out=0; state IDLE.
- Reset asserted mid-instruction aborts it: no register write, no done pulse.
- Latency, with start sampled at edge E0:
  - busy goes high after E0 and stays high for exactly 3 cycles.
  - R[rd] and flags update at E0+3.
  - done is high for the single cycle after E0+3; busy is low in that cycle.
- A new start is accepted in the same cycle done is high (back-to-back throughput: one instruction per 4 cycles).
- An ld is visible on R[rd] (and on out if rd=0) the cycle after its edge.
- done and busy are registered outputs; out and flags come straight from registers.

## Test plan
- Reset and load:
  - Assert reset mid-stream → all outputs 0, state IDLE.
  - ld R0..R3 with 8'h05, 8'h03, 8'hF0, 8'h80 → out=8'h05.
- ADD overflow: R1=8'hFF, R2=8'h01; start op=000 ra=1 rb=2 rd=0 → busy 3 cycles; out=8'h00, z=1, c=1, n=0; done single pulse at cycle 4.
- SUB borrow / SHL:
  - R1=8'h03, R2=8'h05, SUB rd=3 → R3=8'hFE, n=1, c=1.
  - Then SHL ra=2 (8'h80→rd=0) → out=8'h00, c=1, z=1.
- Busy-ignore: issue start, then pulse start and ld with different operands during FETCH/EXEC → only the first instruction executes; target registers of the ignored ld are unchanged.
- Reset mid-op: start ADD rd=0, assert reset during EXEC → R0=0, done never pulses, busy=0 after reset.
- Parameter sweep: WIDTH=16, NREG=8; load R7=16'h8000, R6=16'h8000; ADD rd=0 → out=16'h0000, c=1, z=1; MOVB rb=7 rd=5, then MOVB rb=5 rd=0 → out=16'h8000, n=1, c=0.

Source files
------------

// File: rtl/dp_seq_engine.sv
// rtl/dp_seq_engine.sv - register-file datapath with FETCH/EXEC/WB instruction sequencer
// One ALU instruction per accepted start; R0 is exposed on out.
module dp_seq_engine #(
  parameter  int WIDTH = 8,
  parameter  int NREG  = 4,
  localparam int RW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             ld,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [RW-1:0]    rd,
  input  logic [RW-1:0]    ra,
  input  logic [RW-1:0]    rb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             n,
  output logic             c
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_WB} state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cy_q, cy_d;
  logic [2:0]       op_q, op_d;
  logic [RW-1:0]    rd_q, rd_d;
  logic [RW-1:0]    ra_q, ra_d;
  logic [RW-1:0]    rb_q, rb_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             c_q, c_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic [WIDTH:0]   alu_wide;

  // B operand is read in EXEC, so a WB to the same register cannot race it.
  always_comb begin
    alu_b    = regs_q[rb_q];
    alu_wide = '0;
    alu_res  = '0;
    alu_c    = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_wide = {1'b0, tmp_q} + {1'b0, alu_b};
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      OP_SUB: begin
        alu_wide = {1'b0, tmp_q} - {1'b0, alu_b};
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      OP_AND:  alu_res = tmp_q & alu_b;
      OP_OR:   alu_res = tmp_q | alu_b;
      OP_XOR:  alu_res = tmp_q ^ alu_b;
      OP_SHL: begin
        alu_res = {tmp_q[WIDTH-2:0], 1'b0};
        alu_c   = tmp_q[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, tmp_q[WIDTH-1:1]};
        alu_c   = tmp_q[0];
      end
      default: alu_res = alu_b;
    endcase
  end

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    tmp_d   = tmp_q;
    res_d   = res_q;
    cy_d    = cy_q;
    op_d    = op_q;
    rd_d    = rd_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          rd_d    = rd;
          ra_d    = ra;
          rb_d    = rb;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end else if (ld) begin
          regs_d[rd] = in;
        end
      end
      S_FETCH: begin
        tmp_d   = regs_q[ra_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_res;
        cy_d    = alu_c;
        state_d = S_WB;
      end
      default: begin
        regs_d[rd_q] = res_q;
        z_d          = (res_q == '0);
        n_d          = res_q[WIDTH-1];
        c_d          = cy_q;
        busy_d       = 1'b0;
        done_d       = 1'b1;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      regs_q  <= '{default: '0};
      tmp_q   <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      op_q    <= '0;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      tmp_q   <= tmp_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = regs_q[0];
  assign z    = z_q;
  assign n    = n_q;
  assign c    = c_q;

endmodule

// File: tb/tb_dp_seq_engine.sv
// tb/tb_dp_seq_engine.sv - directed bench for dp_seq_engine at 8x4 and 16x8
module tb_dp_seq_engine;

  logic       clk = 1'b0;
  logic       reset;
  always #5 clk = ~clk;

  logic [7:0] in8;
  logic       ld8, start8, busy8, done8, z8, n8, c8;
  logic [2:0] op8;
  logic [1:0] rd8, ra8, rb8;
  logic [7:0] out8;

  logic [15:0] in16;
  logic        ld16, start16, busy16, done16, z16, n16, c16;
  logic [2:0]  op16;
  logic [2:0]  rd16, ra16, rb16;
  logic [15:0] out16;

  int n_cmp = 0;
  int n_mis = 0;
  int busy_cnt, done_cnt, done_at;

  dp_seq_engine #(.WIDTH(8), .NREG(4)) dut8 (
    .clk(clk), .reset(reset), .in(in8), .ld(ld8), .start(start8), .op(op8),
    .rd(rd8), .ra(ra8), .rb(rb8), .busy(busy8), .done(done8), .out(out8),
    .z(z8), .n(n8), .c(c8)
  );

  dp_seq_engine #(.WIDTH(16), .NREG(8)) dut16 (
    .clk(clk), .reset(reset), .in(in16), .ld(ld16), .start(start16), .op(op16),
    .rd(rd16), .ra(ra16), .rb(rb16), .busy(busy16), .done(done16), .out(out16),
    .z(z16), .n(n16), .c(c16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ld_8(input logic [1:0] r, input logic [7:0] v);
    @(negedge clk);
    ld8 = 1'b1; rd8 = r; in8 = v;
    @(negedge clk);
    ld8 = 1'b0;
  endtask

  // Issues one instruction, then samples six cycles starting the cycle after acceptance.
  task automatic run_8(input logic [2:0] o, input logic [1:0] d, input logic [1:0] a, input logic [1:0] b);
    @(negedge clk);
    op8 = o; rd8 = d; ra8 = a; rb8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int i = 1; i <= 6; i++) begin
      if (busy8) busy_cnt++;
      if (done8) begin done_cnt++; done_at = i; end
      if (i < 6) @(negedge clk);
    end
  endtask

  task automatic ld_16(input logic [2:0] r, input logic [15:0] v);
    @(negedge clk);
    ld16 = 1'b1; rd16 = r; in16 = v;
    @(negedge clk);
    ld16 = 1'b0;
  endtask

  task automatic run_16(input logic [2:0] o, input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    op16 = o; rd16 = d; ra16 = a; rb16 = b; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (3) @(negedge clk);
    check("done16_pulse", {31'b0, done16}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    in8 = '0; ld8 = 0; start8 = 0; op8 = '0; rd8 = '0; ra8 = '0; rb8 = '0;
    in16 = '0; ld16 = 0; start16 = 0; op16 = '0; rd16 = '0; ra16 = '0; rb16 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out", {24'b0, out8}, 32'h0);
    check("rst_flags", {29'b0, z8, n8, c8}, 32'h0);
    check("rst_busy_done", {30'b0, busy8, done8}, 32'h0);

    ld_8(2'd0, 8'h05);
    check("ld_r0_visible", {24'b0, out8}, 32'h05);
    ld_8(2'd1, 8'h03);
    ld_8(2'd2, 8'hF0);
    ld_8(2'd3, 8'h80);
    check("ld_out_r0", {24'b0, out8}, 32'h05);
    check("ld_no_flags", {29'b0, z8, n8, c8}, 32'h0);

    ld_8(2'd1, 8'hFF);
    ld_8(2'd2, 8'h01);
    run_8(3'b000, 2'd0, 2'd1, 2'd2);
    check("add_busy_cycles", busy_cnt, 32'd3);
    check("add_done_count", done_cnt, 32'd1);
    check("add_done_cycle", done_at, 32'd4);
    check("add_out", {24'b0, out8}, 32'h00);
    check("add_znc", {29'b0, z8, n8, c8}, 32'b101);

    ld_8(2'd1, 8'h03);
    ld_8(2'd2, 8'h05);
    run_8(3'b001, 2'd3, 2'd1, 2'd2);
    check("sub_out_r0_kept", {24'b0, out8}, 32'h00);
    check("sub_znc", {29'b0, z8, n8, c8}, 32'b011);
    run_8(3'b111, 2'd0, 2'd0, 2'd3);
    check("movb_r3", {24'b0, out8}, 32'hFE);
    check("movb_znc", {29'b0, z8, n8, c8}, 32'b010);

    ld_8(2'd2, 8'h80);
    check("flags_hold_ld", {29'b0, z8, n8, c8}, 32'b010);
    run_8(3'b101, 2'd0, 2'd2, 2'd0);
    check("shl_out", {24'b0, out8}, 32'h00);
    check("shl_znc", {29'b0, z8, n8, c8}, 32'b101);
    run_8(3'b110, 2'd0, 2'd1, 2'd0);
    check("shr_out", {24'b0, out8}, 32'h01);
    check("shr_znc", {29'b0, z8, n8, c8}, 32'b001);
    run_8(3'b100, 2'd0, 2'd1, 2'd2);
    check("xor_out", {24'b0, out8}, 32'h83);
    check("xor_znc", {29'b0, z8, n8, c8}, 32'b010);

    // Busy-ignore, then a start accepted in the done cycle.
    ld_8(2'd1, 8'h10);
    ld_8(2'd2, 8'h20);
    ld_8(2'd3, 8'h33);
    @(negedge clk);
    op8 = 3'b000; rd8 = 2'd0; ra8 = 2'd1; rb8 = 2'd2; start8 = 1'b1;
    @(negedge clk);
    op8 = 3'b111; rd8 = 2'd2; ra8 = 2'd3; rb8 = 2'd3; ld8 = 1'b1; in8 = 8'hAA;
    done_cnt = 0;
    @(negedge clk);
    if (done8) done_cnt++;
    @(negedge clk);
    if (done8) done_cnt++;
    start8 = 1'b0; ld8 = 1'b0;
    @(negedge clk);
    check("ign_no_early_done", done_cnt, 32'd0);
    check("ign_done", {30'b0, busy8, done8}, 32'b01);
    check("ign_out", {24'b0, out8}, 32'h30);
    op8 = 3'b111; rd8 = 2'd0; ra8 = 2'd0; rb8 = 2'd2; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_busy", {31'b0, busy8}, 32'd1);
    repeat (3) @(negedge clk);
    check("ign_r2_kept", {24'b0, out8}, 32'h20);
    run_8(3'b111, 2'd0, 2'd0, 2'd3);
    check("ign_r3_kept", {24'b0, out8}, 32'h33);

    // Reset during EXEC aborts the instruction.
    @(negedge clk);
    op8 = 3'b000; rd8 = 2'd0; ra8 = 2'd1; rb8 = 2'd2; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstop_out", {24'b0, out8}, 32'h00);
    check("rstop_busy", {31'b0, busy8}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done8) done_cnt++;
    end
    check("rstop_no_done", done_cnt, 32'd0);
    check("rstop_out_after", {24'b0, out8}, 32'h00);

    // 16-bit, 8-register instance.
    ld_16(3'd7, 16'h8000);
    ld_16(3'd6, 16'h8000);
    run_16(3'b000, 3'd0, 3'd7, 3'd6);
    check("w16_add_out", {16'b0, out16}, 32'h0000);
    check("w16_add_znc", {29'b0, z16, n16, c16}, 32'b101);
    run_16(3'b111, 3'd5, 3'd0, 3'd7);
    run_16(3'b111, 3'd0, 3'd0, 3'd5);
    check("w16_movb_out", {16'b0, out16}, 32'h8000);
    check("w16_movb_znc", {29'b0, z16, n16, c16}, 32'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
